// File: rtl/ultrasonic_burst_generator.sv
// Ultrasonic transmit burst generator: N square periods of run-time half-period H,
// complementary drive pair, busy/done handshake, abortable.
module ultrasonic_burst_generator #(
  parameter int DIV_W    = 16,
  parameter int CNT_W    = 8,
  parameter int MIN_HALF = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] half_period,
  input  logic [CNT_W-1:0] num_periods,
  output logic             pulse_out,
  output logic             pulse_out_n,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] half_cnt, half_n;
  logic [CNT_W-1:0] per_cnt, per_n;
  logic [DIV_W-1:0] h_lat, h_n;
  logic [CNT_W-1:0] n_lat, n_n;
  logic             high, high_n;
  logic             accept;
  logic [DIV_W-1:0] heff;

  assign heff = (half_period < DIV_W'(MIN_HALF)) ?
                DIV_W'(MIN_HALF) : half_period;

  assign accept = (state != RUN) && start && !abort;

  always_comb begin
    state_n = state;
    half_n  = half_cnt;
    per_n   = per_cnt;
    high_n  = high;
    h_n     = h_lat;
    n_n     = n_lat;
    case (state)
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (half_cnt == h_lat - DIV_W'(1)) begin
          half_n = '0;
          high_n = ~high;
          // Period boundary sits at the end of the low half.
          if (!high) begin
            if (per_cnt == n_lat - CNT_W'(1)) state_n = DONE;
            else per_n = per_cnt + CNT_W'(1);
          end
        end else begin
          half_n = half_cnt + DIV_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        if (accept) begin
          h_n     = heff;
          n_n     = num_periods;
          half_n  = '0;
          per_n   = '0;
          high_n  = 1'b1;
          state_n = (num_periods == '0) ? DONE : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      half_cnt    <= '0;
      per_cnt     <= '0;
      h_lat       <= '0;
      n_lat       <= '0;
      high        <= 1'b0;
      pulse_out   <= 1'b0;
      pulse_out_n <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      half_cnt    <= half_n;
      per_cnt     <= per_n;
      h_lat       <= h_n;
      n_lat       <= n_n;
      high        <= high_n;
      pulse_out   <= (state_n == RUN) && high_n;
      pulse_out_n <= (state_n == RUN) && !high_n;
      busy        <= (state_n == RUN);
      done        <= (state_n == DONE);
    end
  end

endmodule
